// File: rtl/register_pkg.sv
// Shared ctrl opcode definitions for the register block.
package register_pkg;

  localparam int unsigned CTRL_WIDTH = 3;

  typedef logic [CTRL_WIDTH-1:0] ctrl_t;

  localparam ctrl_t NONE                = 3'd0;
  localparam ctrl_t CLR                 = 3'd1;
  localparam ctrl_t PARALLEL_LOAD       = 3'd2;
  localparam ctrl_t SERIAL_MSB_LOAD     = 3'd3;
  localparam ctrl_t SERIAL_LSB_LOAD     = 3'd4;
  localparam ctrl_t SHIFT_LOGICAL_LEFT  = 3'd5;
  localparam ctrl_t SHIFT_LOGICAL_RIGHT = 3'd6;
  localparam ctrl_t ROTATE_RIGHT        = 3'd7;

endpackage

// File: rtl/register_next_value.sv
// Combinational next-state logic for the shift/load register.
// Optional macro REGISTER_ROTATE_EN turns ctrl=ROTATE_RIGHT into a rotate; otherwise it holds.
module register_next_value
  import register_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]      cur_value,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic                  serial_data_input,
  input  logic [WIDTH-1:0]      parallel_data_input,
  output logic [WIDTH-1:0]      next_value
);

  always_comb begin
    next_value = cur_value;
    case (ctrl)
      NONE:                next_value = cur_value;
      CLR:                 next_value = '0;
      PARALLEL_LOAD:       next_value = parallel_data_input;
      SERIAL_MSB_LOAD:     next_value = {serial_data_input, cur_value[WIDTH-1:1]};
      SERIAL_LSB_LOAD:     next_value = {cur_value[WIDTH-2:0], serial_data_input};
      SHIFT_LOGICAL_LEFT:  next_value = {cur_value[WIDTH-2:0], 1'b0};
      SHIFT_LOGICAL_RIGHT: next_value = {1'b0, cur_value[WIDTH-1:1]};
`ifdef REGISTER_ROTATE_EN
      ROTATE_RIGHT:        next_value = {cur_value[0], cur_value[WIDTH-1:1]};
`endif
      default:             next_value = cur_value;
    endcase
  end

endmodule

// File: rtl/register.sv
// Shift/load register: async-reset flop bank fed by register_next_value.
// Optional macro REGISTER_ROTATE_EN enables rotate-right on ctrl=7.
module register
  import register_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic                  serial_data_input,
  input  logic [WIDTH-1:0]      parallel_data_input,
  output logic [WIDTH-1:0]      data_output
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  register_next_value #(
    .WIDTH(WIDTH)
  ) u_next_value (
    .cur_value          (data_q),
    .ctrl               (ctrl),
    .serial_data_input  (serial_data_input),
    .parallel_data_input(parallel_data_input),
    .next_value         (data_d)
  );

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_output = data_q;

endmodule

// File: tb/tb_register.sv
// Directed and randomized bench for the register block, checked against an arithmetic model.
module tb_register;
  import register_pkg::*;

  localparam int W = 8;
  localparam int MOD = 1 << W;

  logic                  clk;
  logic                  async_nreset;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  sdi;
  logic [W-1:0]          pdi;
  logic [W-1:0]          dout;

  int total;
  int bad;
  int m;

  register #(
    .WIDTH(W)
  ) dut (
    .clk                (clk),
    .async_nreset       (async_nreset),
    .ctrl               (ctrl),
    .serial_data_input  (sdi),
    .parallel_data_input(pdi),
    .data_output        (dout)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  // Reference behaviour expressed as integer arithmetic on the register value.
  function automatic int model_next(input int v, input int op, input int s, input int p);
    case (op)
      0: return v;
      1: return 0;
      2: return p;
      3: return v / 2 + s * (MOD / 2);
      4: return (v * 2 + s) % MOD;
      5: return (v * 2) % MOD;
      6: return v / 2;
`ifdef REGISTER_ROTATE_EN
      7: return v / 2 + (v % 2) * (MOD / 2);
`else
      7: return v;
`endif
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] exp);
    total++;
    assert (dout === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, dout, exp);
    end
  endtask

  task automatic step(input int op, input logic s, input logic [W-1:0] p);
    @(negedge clk);
    ctrl = CTRL_WIDTH'(op);
    sdi  = s;
    pdi  = p;
    @(posedge clk);
    m = model_next(m, op, int'(s), int'(p));
    #1;
  endtask

  initial begin
    logic [W-1:0] rnd;
    logic [W-1:0] rot_exp;
    total = 0;
    bad   = 0;
    m     = 0;

    // Reset held for 2.5 periods while load is requested; must stay zero.
    async_nreset = 1'b0;
    ctrl = PARALLEL_LOAD;
    sdi  = 1'b1;
    pdi  = 8'hFF;
    #1  chk("rst_immediate", 8'h00);
    #9  chk("rst_hold_a", 8'h00);
    #10 chk("rst_hold_b", 8'h00);
    ctrl = NONE;
    #5 async_nreset = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_none", 8'h00);

    step(PARALLEL_LOAD, 1'b0, 8'b1100_0011);
    chk("pload_c3", 8'b1100_0011);
    step(SERIAL_MSB_LOAD, 1'b1, 8'h5A);
    chk("smsb_1", 8'b1110_0001);

    step(PARALLEL_LOAD, 1'b0, 8'b1100_0011);
    step(SERIAL_LSB_LOAD, 1'b1, 8'h00);
    chk("slsb_1", 8'b1000_0111);
    step(SERIAL_LSB_LOAD, 1'b0, 8'hFF);
    chk("slsb_0", 8'b0000_1110);

    step(PARALLEL_LOAD, 1'b0, 8'b1000_0001);
    step(SHIFT_LOGICAL_LEFT, 1'b1, 8'hFF);
    chk("sll", 8'b0000_0010);
    step(SHIFT_LOGICAL_RIGHT, 1'b1, 8'hFF);
    chk("slr", 8'b0000_0001);
    for (int i = 0; i < W; i++) step(SHIFT_LOGICAL_RIGHT, 1'b1, 8'hFF);
    chk("slr_no_wrap", 8'b0000_0000);
    step(PARALLEL_LOAD, 1'b0, 8'hFF);
    for (int i = 0; i < W; i++) step(SHIFT_LOGICAL_LEFT, 1'b1, 8'hFF);
    chk("sll_no_wrap", 8'b0000_0000);

    step(PARALLEL_LOAD, 1'b0, 8'h5A);
    for (int i = 0; i < 3; i++) step(NONE, logic'(i % 2), 8'hA5 ^ 8'(i));
    chk("hold", 8'h5A);
    step(CLR, 1'b1, 8'hFF);
    chk("clr", 8'h00);
    step(PARALLEL_LOAD, 1'b0, 8'b0000_0001);
    step(ROTATE_RIGHT, 1'b0, 8'hFF);
`ifdef REGISTER_ROTATE_EN
    rot_exp = 8'b1000_0000;
`else
    rot_exp = 8'b0000_0001;
`endif
    chk("ctrl7", rot_exp);

    // Reset between edges during a serial load.
    step(PARALLEL_LOAD, 1'b0, 8'h3C);
    @(negedge clk);
    ctrl = SERIAL_MSB_LOAD;
    sdi  = 1'b1;
    #2 async_nreset = 1'b0;
    m = 0;
    #1 chk("midop_rst_async", 8'h00);
    @(posedge clk);
    #1 chk("midop_rst_edge1", 8'h00);
    @(posedge clk);
    #1 chk("midop_rst_edge2", 8'h00);
    // First edge after release executes the sampled operation.
    @(negedge clk);
    ctrl = PARALLEL_LOAD;
    pdi  = 8'h96;
    #2 async_nreset = 1'b1;
    @(posedge clk);
    m = 'h96;
    #1 chk("first_edge_op", 8'h96);

    for (int i = 0; i < 300; i++) begin
      rnd = 8'($urandom);
      step(int'($urandom_range(7, 0)), logic'($urandom_range(1, 0)), rnd);
      chk("random", 8'(m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
